// File: rtl/riscv_mem_pkg.sv
// Shared memory-side definitions for the RISC-V core: store/load size codes
// and the store buffer entry layout.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_SW     = 2'b00,
        ST_SH     = 2'b01,
        ST_SB     = 2'b10,
        ST_SW_ALT = 2'b11
    } st_size_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_size_e;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
        st_size_e              strb;
    } stb_entry_t;

    // A store writes the full word for SW and for the reserved 11 code.
    function automatic logic is_word_store(input logic [1:0] strb);
        return (strb == ST_SW) || (strb == ST_SW_ALT);
    endfunction

endpackage

// File: rtl/stb_match.sv
// Word-address compare of a load against every valid store buffer entry,
// plus selection of the youngest matching entry (youngest = closest behind tail).
module stb_match #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned WORD_W = 30,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WORD_W-1:0] entry_word_i,
    input  logic [DEPTH-1:0]             entry_valid_i,
    input  logic [PTR_W-1:0]             tail_i,
    input  logic [WORD_W-1:0]            ld_word_i,
    output logic                         any_match_o,
    output logic [PTR_W-1:0]             young_idx_o
);

    logic [DEPTH-1:0] hit;
    logic [PTR_W-1:0] idx;

    // Per-entry word-address hit.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit[i] = entry_valid_i[i] && (entry_word_i[i] == ld_word_i);
        end
    end

    // Walk from tail (oldest slot) forward; the last hit seen is the youngest.
    always_comb begin
        any_match_o = |hit;
        young_idx_o = '0;
        idx         = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail_i + PTR_W'(k);
            if (hit[idx]) begin
                young_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and the data memory write port.
// Stores are queued, drained one per cycle when drain_en allows, and loads are
// checked against pending stores. Define STB_FWD_EN to forward full-word store
// data to a matching load instead of stalling it.
module store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_strb,
    input  logic              drain_en,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [DATA_W-1:0] wr_din0,
    output logic [1:0]        wr_strb,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_conflict,
    output logic              ld_fwd_valid,
    output logic [DATA_W-1:0] ld_fwd_data,
    output logic              empty
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = ADDR_W - 2;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [1:0]        strb_q [DEPTH];

    logic full, push, pop;
    logic [DEPTH-1:0][WORD_W-1:0] entry_word;
    logic                         any_match;
    logic [PTR_W-1:0]             young_idx;
    logic                         unused_ld_lsb;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign st_ready = !full;
    assign push     = st_valid && !full;
    assign pop      = !empty && drain_en;
    assign unused_ld_lsb = ^ld_addr[1:0];

    // Next pointer, count and valid-bit state from push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards all pending stores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload write at tail; payload is qualified by valid_q so needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            strb_q[tail_q] <= st_strb;
        end
    end

    // Memory write port driven straight from the head entry.
    always_comb begin
        we0      = pop;
        wr_addr0 = empty ? '0 : addr_q[head_q];
        wr_din0  = empty ? '0 : data_q[head_q];
        wr_strb  = empty ? '0 : strb_q[head_q];
    end

    // Word addresses of all entries for the load check.
    always_comb begin
        entry_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_word[i] = addr_q[i][ADDR_W-1:2];
        end
    end

    stb_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_match (
        .entry_word_i  (entry_word),
        .entry_valid_i (valid_q),
        .tail_i        (tail_q),
        .ld_word_i     (ld_addr[ADDR_W-1:2]),
        .any_match_o   (any_match),
        .young_idx_o   (young_idx)
    );

`ifdef STB_FWD_EN
    logic young_is_word;
    assign young_is_word = is_word_store(strb_q[young_idx]);

    // Youngest match decides: full-word stores forward, partial stores stall.
    always_comb begin
        ld_fwd_valid = ld_valid && any_match && young_is_word;
        ld_conflict  = ld_valid && any_match && !young_is_word;
        ld_fwd_data  = ld_fwd_valid ? data_q[young_idx] : '0;
    end
`else
    logic unused_young_idx;
    assign unused_young_idx = ^young_idx;

    // Without forwarding any pending match stalls the load.
    always_comb begin
        ld_conflict  = ld_valid && any_match;
        ld_fwd_valid = 1'b0;
        ld_fwd_data  = '0;
    end
`endif

endmodule
